// File: rtl/bsg_ready_and_link_wh_rr_concentrator.sv
// Wormhole concentrator: merges num_in_p ready_and links onto one link with
// round-robin packet arbitration, and routes the return path by header cid.

module bsg_ready_and_link_wh_rr_concentrator_fifo2 #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);
   logic [width_p-1:0] mem_q [2];
   logic               wrPtr_q, wrPtr_d;
   logic               rdPtr_q, rdPtr_d;
   logic [1:0]         count_q, count_d;
   logic               enq, deq;

   // Handshakes are masked while reset is held so nothing moves during reset.
   assign ready_o = (count_q != 2'd2) && !reset_i;
   assign v_o     = (count_q != 2'd0) && !reset_i;
   assign data_o  = mem_q[rdPtr_q];
   assign enq     = v_i && ready_o;
   assign deq     = yumi_i && v_o;

   always_comb begin
      wrPtr_d = wrPtr_q ^ enq;
      rdPtr_d = rdPtr_q ^ deq;
      count_d = count_q;
      if (enq && !deq) begin
         count_d = count_q + 2'd1;
      end else if (deq && !enq) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wrPtr_q <= 1'b0;
         rdPtr_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end
endmodule

module bsg_ready_and_link_wh_rr_concentrator #(
   parameter int width_p      = 16,
   parameter int num_in_p     = 2,
   parameter int cord_width_p = 4,
   parameter int len_width_p  = 4,
   parameter int cid_width_p  = 4
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [num_in_p-1:0][width_p+1:0]  links_i,
   output logic [num_in_p-1:0][width_p+1:0]  links_o,
   input  logic [width_p+1:0]                single_link_i,
   output logic [width_p+1:0]                single_link_o,
   output logic                              cid_err_o
);
   localparam int selWidth = (num_in_p > 1) ? $clog2(num_in_p) : 1;
   localparam int cidLsb   = cord_width_p + len_width_p;

   typedef enum logic {eIdle, eLocked} state_e;

   logic [num_in_p-1:0]              fwdV, fwdReady, fwdYumi;
   logic [num_in_p-1:0][width_p-1:0] fwdData;
   logic                             revV, revReady, revYumi;
   logic [width_p-1:0]               revData;

   for (genvar k = 0; k < num_in_p; k++) begin : g_in
      bsg_ready_and_link_wh_rr_concentrator_fifo2 #(.width_p(width_p)) fifo (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .v_i     (links_i[k][width_p+1]),
         .data_i  (links_i[k][width_p:1]),
         .ready_o (fwdReady[k]),
         .v_o     (fwdV[k]),
         .data_o  (fwdData[k]),
         .yumi_i  (fwdYumi[k])
      );
   end

   bsg_ready_and_link_wh_rr_concentrator_fifo2 #(.width_p(width_p)) singleFifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (single_link_i[width_p+1]),
      .data_i  (single_link_i[width_p:1]),
      .ready_o (revReady),
      .v_o     (revV),
      .data_o  (revData),
      .yumi_i  (revYumi)
   );

   function automatic logic [selWidth-1:0] nextPtr(input logic [selWidth-1:0] p);
      if (int'(p) == num_in_p - 1) return '0;
      return p + selWidth'(1);
   endfunction

   state_e                fwdState_q, fwdState_d;
   logic [selWidth-1:0]   fwdSel_q, fwdSel_d, rrPtr_q, rrPtr_d;
   logic [len_width_p-1:0] fwdRem_q, fwdRem_d;
   logic [selWidth-1:0]   fwdGrant;
   logic                  fwdFound, fwdOutV, fwdSend;
   logic [width_p-1:0]    fwdOutData;
   int                    fwdIdx;

   // Forward arbiter: search from rrPtr in IDLE, stick to one source while LOCKED.
   always_comb begin
      fwdState_d = fwdState_q;
      fwdSel_d   = fwdSel_q;
      fwdRem_d   = fwdRem_q;
      rrPtr_d    = rrPtr_q;
      fwdGrant   = fwdSel_q;
      fwdFound   = 1'b0;
      fwdIdx     = 0;
      if (fwdState_q == eIdle) begin
         fwdGrant = rrPtr_q;
         for (int i = 0; i < num_in_p; i++) begin
            fwdIdx = int'(rrPtr_q) + i;
            if (fwdIdx >= num_in_p) fwdIdx = fwdIdx - num_in_p;
            if (!fwdFound && fwdV[fwdIdx]) begin
               fwdFound = 1'b1;
               fwdGrant = selWidth'(fwdIdx);
            end
         end
      end
      fwdOutV    = fwdV[fwdGrant];
      fwdOutData = fwdData[fwdGrant];
      fwdSend    = fwdOutV && single_link_i[0];
      fwdYumi    = '0;
      fwdYumi[fwdGrant] = fwdSend;
      if (fwdSend) begin
         if (fwdState_q == eIdle) begin
            if (fwdOutData[cord_width_p +: len_width_p] == '0) begin
               rrPtr_d = nextPtr(fwdGrant);
            end else begin
               fwdState_d = eLocked;
               fwdSel_d   = fwdGrant;
               fwdRem_d   = fwdOutData[cord_width_p +: len_width_p];
            end
         end else begin
            fwdRem_d = fwdRem_q - len_width_p'(1);
            if (fwdRem_q == len_width_p'(1)) begin
               fwdState_d = eIdle;
               rrPtr_d    = nextPtr(fwdSel_q);
            end
         end
      end
   end

   state_e                 revState_q, revState_d;
   logic [selWidth-1:0]    revDst_q, revDst_d;
   logic [len_width_p-1:0] revRem_q, revRem_d;
   logic                   cidErr_q, cidErr_d;
   logic [cid_width_p-1:0] revCid;
   logic                   revCidBad, revSend;
   logic [selWidth-1:0]    revHdrDst, revDst;

   // Out-of-range cids are folded onto the last link and flagged until reset.
   always_comb begin
      revState_d = revState_q;
      revDst_d   = revDst_q;
      revRem_d   = revRem_q;
      cidErr_d   = cidErr_q;
      revCid     = revData[cidLsb +: cid_width_p];
      revCidBad  = int'(revCid) >= num_in_p;
      revHdrDst  = revCidBad ? selWidth'(num_in_p - 1) : revCid[selWidth-1:0];
      revDst     = (revState_q == eIdle) ? revHdrDst : revDst_q;
      revSend    = revV && links_i[revDst][0];
      revYumi    = revSend;
      if (revSend) begin
         if (revState_q == eIdle) begin
            cidErr_d = cidErr_q || revCidBad;
            if (revData[cord_width_p +: len_width_p] != '0) begin
               revState_d = eLocked;
               revDst_d   = revHdrDst;
               revRem_d   = revData[cord_width_p +: len_width_p];
            end
         end else begin
            revRem_d = revRem_q - len_width_p'(1);
            if (revRem_q == len_width_p'(1)) begin
               revState_d = eIdle;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fwdState_q <= eIdle;
         fwdSel_q   <= '0;
         fwdRem_q   <= '0;
         rrPtr_q    <= '0;
         revState_q <= eIdle;
         revDst_q   <= '0;
         revRem_q   <= '0;
         cidErr_q   <= 1'b0;
      end else begin
         fwdState_q <= fwdState_d;
         fwdSel_q   <= fwdSel_d;
         fwdRem_q   <= fwdRem_d;
         rrPtr_q    <= rrPtr_d;
         revState_q <= revState_d;
         revDst_q   <= revDst_d;
         revRem_q   <= revRem_d;
         cidErr_q   <= cidErr_d;
      end
   end

   always_comb begin
      links_o = '0;
      for (int k = 0; k < num_in_p; k++) begin
         links_o[k] = {(revV && (int'(revDst) == k)), revData, fwdReady[k]};
      end
   end

   assign single_link_o = {fwdOutV, fwdOutData, revReady};
   assign cid_err_o     = cidErr_q;
endmodule

// File: tb/tb_bsg_ready_and_link_wh_rr_concentrator.sv
// Directed bench for the wormhole concentrator: per-link flit drivers feed the
// DUT while negedge monitors pop hand-ordered expectations from scoreboards.

module tb_bsg_ready_and_link_wh_rr_concentrator;
   localparam int W    = 16;
   localparam int N    = 4;
   localparam int CORD = 4;
   localparam int LEN  = 3;
   localparam int CID  = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [N-1:0][W+1:0] links_i, links_o;
   logic [W+1:0]        single_link_i, single_link_o;
   logic                cid_err_o;

   logic [N-1:0] lnkV, linkReady;
   logic [N-1:0] lnkHs = '0;
   logic [W-1:0] lnkData [N];
   logic         sinV, singleReady;
   logic         sinHs = 1'b0;
   logic [W-1:0] sinData;

   typedef struct packed {
      logic [1:0]   dst;
      logic [W-1:0] data;
   } revItem_t;

   logic [W-1:0] srcQ [N][$];
   logic [W-1:0] sinQ [$];
   logic [W-1:0] fwdExp [$];
   revItem_t     revExp [$];
   int           fwdCycles [$];
   int           total = 0;
   int           bad = 0;
   int           cycleCnt = 0;

   bsg_ready_and_link_wh_rr_concentrator #(
      .width_p      (W),
      .num_in_p     (N),
      .cord_width_p (CORD),
      .len_width_p  (LEN),
      .cid_width_p  (CID)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .links_i       (links_i),
      .links_o       (links_o),
      .single_link_i (single_link_i),
      .single_link_o (single_link_o),
      .cid_err_o     (cid_err_o)
   );

   always_comb begin
      for (int k = 0; k < N; k++) begin
         links_i[k] = {lnkV[k], lnkData[k], linkReady[k]};
      end
      single_link_i = {sinV, sinData, singleReady};
   end

   function automatic logic [W-1:0] hdr(input int tag, input int cid, input int len);
      return {6'(tag), 3'(cid), 3'(len), 4'hA};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input int src, input logic [W-1:0] flit);
      if (src == N) sinQ.push_back(flit);
      else srcQ[src].push_back(flit);
   endtask

   task automatic expFwd(input logic [W-1:0] flit);
      fwdExp.push_back(flit);
   endtask

   task automatic expRev(input int dst, input logic [W-1:0] flit);
      revItem_t it;
      it.dst  = 2'(dst);
      it.data = flit;
      revExp.push_back(it);
   endtask

   task automatic waitDrain(input string name);
      int c = 0;
      while ((fwdExp.size() != 0 || revExp.size() != 0) && c < 300) begin
         tick();
         c++;
      end
      checkOutput({name, "_drain"}, fwdExp.size() + revExp.size(), 0);
      fwdExp.delete();
      revExp.delete();
      repeat (5) tick();
   endtask

   // Drivers present the queue head and pop it once the negedge saw a handshake.
   initial begin
      lnkV  = '0;
      sinV  = 1'b0;
      sinData = '0;
      for (int k = 0; k < N; k++) lnkData[k] = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if (lnkHs[k] && srcQ[k].size() > 0) void'(srcQ[k].pop_front());
            if (srcQ[k].size() > 0) begin
               lnkV[k]    = 1'b1;
               lnkData[k] = srcQ[k][0];
            end else begin
               lnkV[k] = 1'b0;
            end
         end
         if (sinHs && sinQ.size() > 0) void'(sinQ.pop_front());
         if (sinQ.size() > 0) begin
            sinV    = 1'b1;
            sinData = sinQ[0];
         end else begin
            sinV = 1'b0;
         end
      end
   end

   // Monitors: any forward or reverse transfer must match the scoreboard head.
   initial begin
      logic [N-1:0] revVs;
      logic [W-1:0] e;
      revItem_t     it;
      int           d;
      forever begin
         @(negedge clk);
         cycleCnt++;
         for (int k = 0; k < N; k++) lnkHs[k] = lnkV[k] & links_o[k][0];
         sinHs = sinV & single_link_o[0];
         if (single_link_o[W+1] && singleReady) begin
            fwdCycles.push_back(cycleCnt);
            if (fwdExp.size() == 0) begin
               checkOutput("fwd_unexpected", single_link_o[W:1], 32'hFFFF_FFFF);
            end else begin
               e = fwdExp.pop_front();
               checkOutput("fwd_data", single_link_o[W:1], e);
            end
         end
         for (int k = 0; k < N; k++) revVs[k] = links_o[k][W+1];
         if (revVs != '0) begin
            checkOutput("rev_onehot", $onehot(revVs), 1);
            d = 0;
            for (int k = 0; k < N; k++) if (revVs[k]) d = k;
            if (linkReady[d]) begin
               if (revExp.size() == 0) begin
                  checkOutput("rev_unexpected", links_o[d][W:1], 32'hFFFF_FFFF);
               end else begin
                  it = revExp.pop_front();
                  checkOutput("rev_dst", d, it.dst);
                  checkOutput("rev_data", links_o[d][W:1], it.data);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [N-1:0] vBits, rBits;
      int c;
      reset       = 1'b1;
      singleReady = 1'b0;
      linkReady   = '0;
      tick();
      tick();
      for (int k = 0; k < N; k++) begin
         vBits[k] = links_o[k][W+1];
         rBits[k] = links_o[k][0];
      end
      checkOutput("reset_single_v", single_link_o[W+1], 0);
      checkOutput("reset_single_ready", single_link_o[0], 0);
      checkOutput("reset_links_v", vBits, 0);
      checkOutput("reset_links_ready", rBits, 0);
      checkOutput("reset_cid_err", cid_err_o, 0);
      reset = 1'b0;
      #1;
      for (int k = 0; k < N; k++) rBits[k] = links_o[k][0];
      checkOutput("post_reset_single_ready", single_link_o[0], 1);
      checkOutput("post_reset_links_ready", rBits, 4'hF);
      singleReady = 1'b1;
      linkReady   = '1;
      tick();

      // len=3 from link0 races a len=0 header from link1, reverse traffic alongside
      applyStimulus(0, hdr(1, 0, 3));
      applyStimulus(0, 16'hB001);
      applyStimulus(0, 16'hB002);
      applyStimulus(0, 16'hB003);
      applyStimulus(1, hdr(2, 0, 0));
      applyStimulus(N, hdr(3, 0, 1));
      applyStimulus(N, 16'hC001);
      expFwd(hdr(1, 0, 3));
      expFwd(16'hB001);
      expFwd(16'hB002);
      expFwd(16'hB003);
      expFwd(hdr(2, 0, 0));
      expRev(0, hdr(3, 0, 1));
      expRev(0, 16'hC001);
      waitDrain("t1");

      // maximum length packet; rrPtr is 2 so link2 wins over link3
      applyStimulus(2, hdr(4, 0, 7));
      for (int i = 1; i <= 7; i++) applyStimulus(2, 16'hB200 + 16'(i));
      applyStimulus(3, hdr(5, 0, 0));
      expFwd(hdr(4, 0, 7));
      for (int i = 1; i <= 7; i++) expFwd(16'hB200 + 16'(i));
      expFwd(hdr(5, 0, 0));
      waitDrain("t2_maxlen");

      linkReady[1] = 1'b0;
      applyStimulus(N, hdr(6, 1, 2));
      applyStimulus(N, 16'hD001);
      applyStimulus(N, 16'hD002);
      applyStimulus(0, hdr(7, 0, 1));
      applyStimulus(0, 16'hF001);
      expRev(1, hdr(6, 1, 2));
      expRev(1, 16'hD001);
      expRev(1, 16'hD002);
      expFwd(hdr(7, 0, 1));
      expFwd(16'hF001);
      tick();
      tick();
      linkReady[1] = 1'b1;
      tick();
      linkReady[1] = 1'b0;
      tick();
      linkReady[1] = 1'b1;
      waitDrain("t3_toggle");

      checkOutput("cid_err_before", cid_err_o, 0);
      applyStimulus(N, hdr(8, 5, 1));
      applyStimulus(N, 16'hE001);
      expRev(3, hdr(8, 5, 1));
      expRev(3, 16'hE001);
      waitDrain("t4_badcid");
      checkOutput("cid_err_set", cid_err_o, 1);
      applyStimulus(N, hdr(9, 2, 0));
      expRev(2, hdr(9, 2, 0));
      waitDrain("t4_after");
      checkOutput("cid_err_sticky", cid_err_o, 1);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("cid_err_cleared", cid_err_o, 0);

      fwdCycles.delete();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < N; k++) begin
            applyStimulus(k, hdr(16 + 4 * r + k, 0, 0));
            expFwd(hdr(16 + 4 * r + k, 0, 0));
         end
      end
      waitDrain("t5_rr");
      checkOutput("rr_stream_count", fwdCycles.size(), 8);
      if (fwdCycles.size() == 8) begin
         checkOutput("rr_stream_span", fwdCycles[7] - fwdCycles[0], 7);
      end

      // move rrPtr to 2, then kill a len=5 packet after its second flit
      applyStimulus(1, hdr(30, 0, 0));
      expFwd(hdr(30, 0, 0));
      waitDrain("t6_prep");
      applyStimulus(0, hdr(31, 0, 5));
      for (int i = 1; i <= 5; i++) applyStimulus(0, 16'hA500 + 16'(i));
      expFwd(hdr(31, 0, 5));
      expFwd(16'hA501);
      c = 0;
      while (fwdExp.size() != 0 && c < 100) begin
         tick();
         c++;
      end
      checkOutput("pkt5_first_two", fwdExp.size(), 0);
      singleReady = 1'b0;
      reset       = 1'b1;
      for (int k = 0; k < N; k++) srcQ[k].delete();
      sinQ.delete();
      fwdExp.delete();
      tick();
      reset       = 1'b0;
      singleReady = 1'b1;
      applyStimulus(3, hdr(33, 0, 0));
      applyStimulus(1, hdr(32, 0, 0));
      expFwd(hdr(32, 0, 0));
      expFwd(hdr(33, 0, 0));
      waitDrain("t6_after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
